mac_sequencer: RTL and testbench
================================

# mac_sequencer

Sequencer that drives the 16-bit accumulator datapath to compute one dot product of the matrix multiplier: C[c_addr] = Σ A[a_base+i] · B[b_base+i·b_stride] for i = 0..len−1. It sits between the top-level matrix control, which issues one `start` per output element, and the shared single-port data memory, operand register and accumulator. It owns the memory address bus and the accumulator control strobes while busy.

## Interface
- `AW`, 8, memory address width
- `LW`, 8, element-count width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin a dot product; sampled only in IDLE
- `abort`  in  1  synchronous cancel; highest priority after reset
- `len`  in  LW  element count; captured at start
- `a_base`  in  AW  address of A row element 0; captured at start
- `b_base`  in  AW  address of B column element 0; captured at start
- `b_stride`  in  AW  address step between B elements; captured at start
- `c_addr`  in  AW  result address; captured at start
- `mem_addr`  out  AW  memory address
- `mem_rd`  out  1  read strobe; data valid on the memory bus the following cycle
- `mem_wr`  out  1  write strobe; memory writes the accumulator output
- `opa_load`  out  1  operand register captures memory data (A element)
- `ac_clear`  out  1  accumulator clear
- `ac_alu_load`  out  1  accumulator loads ALU result (AC + opa · mem_data)
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the result write

## Operation
- States: IDLE, CLR, FA, FB, MAC, WB, DONE.
- IDLE: all outputs 0. `start`=1 → captures the operands, loads `a_ptr`=a_base, `b_ptr`=b_base, `cnt`=len → CLR.
- CLR: `ac_clear`=1. → FA if cnt≠0, else → WB.
- FA: `mem_addr`=a_ptr, `mem_rd`=1 → FB.
- FB: `mem_addr`=b_ptr, `mem_rd`=1, `opa_load`=1 (captures the A data returned this cycle) → MAC.
- MAC: `ac_alu_load`=1 (B data is on the bus this cycle); a_ptr+=1, b_ptr+=b_stride, cnt−=1; → FA if the new cnt≠0, else → WB.
- WB: `mem_addr`=c_addr, `mem_wr`=1 → DONE.
- DONE: `done`=1 → IDLE.
- Pointer arithmetic is modulo 2^AW; wrap past the top address is legal and silent. cnt is LW bits wide.
- Per cycle, at most one of `ac_clear`, `ac_alu_load` is asserted, and at most one of `mem_rd`, `mem_wr`. All outputs are registered-state decodes with no combinational path from inputs.
- `start` while busy is ignored; the captured operands do not change.
- `abort`=1 in any non-IDLE state → IDLE next edge, with no write and no `done`. Accumulator contents are then undefined to the caller.
- `start` and `abort` together in IDLE: abort wins and the block stays in IDLE.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0; internal pointers and cnt 0.
- `start` sampled at edge k → `busy` rises after edge k. CLR occupies cycle k+1, and the first FA cycle k+2.
- Each element takes exactly 3 cycles (FA, FB, MAC).
- `busy` is high for 3·len+3 cycles. `done` is high in the last of these and `busy` is still high with it. `busy` falls on the next edge.
- len=0: CLR, WB, DONE, i.e. 3 busy cycles, and 0 is written to c_addr.
- A new `start` is accepted in the first IDLE cycle after DONE, with no dead cycle beyond it.
- `rst_n` low mid-operation: immediate return to IDLE; all strobes drop asynchronously.

## Test plan
- len=3, a_base=0x10, b_base=0x20, b_stride=4. A=[1,2,3], B at 0x20/0x24/0x28=[4,5,6]. Required: reads in the order 0x10,0x20,0x11,0x24,0x12,0x28; 32 written to c_addr; `done` exactly 12 cycles after the start edge.
- len=0, c_addr=0x05 → `ac_clear` once, then `mem_wr` to 0x05 writing 0 with no reads; `done` on the 3rd busy cycle.
- a_base=0xFE, b_base=0xF0, b_stride=0x08, len=3 → A addresses 0xFE,0xFF,0x00; B addresses 0xF0,0xF8,0x00.
- `start` pulsed again during the MAC state of element 1 → ignored; the original result and cycle count are unchanged.
- `abort` in FB of element 2 → IDLE next cycle, with no `mem_wr` and no `done`. A following start with len=1 completes normally in 6 cycles.
- `rst_n` asserted low during FA → all outputs 0 immediately, state IDLE. After release, the next start operates correctly.

Source files
------------

// File: rtl/mac_sequencer_if.sv
// rtl/mac_sequencer_if.sv - control and memory/accumulator strobe bundle for the dot-product sequencer
interface mac_sequencer_if #(
  parameter int AW = 8,
  parameter int LW = 8
);
  logic          start;
  logic          abort;
  logic [LW-1:0] len;
  logic [AW-1:0] a_base;
  logic [AW-1:0] b_base;
  logic [AW-1:0] b_stride;
  logic [AW-1:0] c_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic          opa_load;
  logic          ac_clear;
  logic          ac_alu_load;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, len, a_base, b_base, b_stride, c_addr,
    input  mem_addr, mem_rd, mem_wr, opa_load, ac_clear, ac_alu_load, busy, done
  );

  modport slave (
    input  start, abort, len, a_base, b_base, b_stride, c_addr,
    output mem_addr, mem_rd, mem_wr, opa_load, ac_clear, ac_alu_load, busy, done
  );
endinterface

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - sequences fetch/multiply-accumulate/writeback for one dot-product element
module mac_sequencer #(
  parameter int AW = 8,
  parameter int LW = 8
) (
  input logic            clk,
  input logic            rst_n,
  mac_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FA,
    S_FB,
    S_MAC,
    S_WB,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] a_ptr_q, a_ptr_d;
  logic [AW-1:0] b_ptr_q, b_ptr_d;
  logic [AW-1:0] stride_q, stride_d;
  logic [AW-1:0] c_addr_q, c_addr_d;
  logic [LW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_ptr_q  <= '0;
      b_ptr_q  <= '0;
      stride_q <= '0;
      c_addr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_ptr_q  <= a_ptr_d;
      b_ptr_q  <= b_ptr_d;
      stride_q <= stride_d;
      c_addr_q <= c_addr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Abort is checked first so a simultaneous start in IDLE captures nothing.
  always_comb begin
    state_d  = state_q;
    a_ptr_d  = a_ptr_q;
    b_ptr_d  = b_ptr_q;
    stride_d = stride_q;
    c_addr_d = c_addr_q;
    cnt_d    = cnt_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_ptr_d  = bus.a_base;
            b_ptr_d  = bus.b_base;
            stride_d = bus.b_stride;
            c_addr_d = bus.c_addr;
            cnt_d    = bus.len;
            state_d  = S_CLR;
          end
        end
        S_CLR:  state_d = (cnt_q != '0) ? S_FA : S_WB;
        S_FA:   state_d = S_FB;
        S_FB:   state_d = S_MAC;
        S_MAC: begin
          a_ptr_d = a_ptr_q + AW'(1);
          b_ptr_d = b_ptr_q + stride_q;
          cnt_d   = cnt_q - LW'(1);
          state_d = (cnt_q != LW'(1)) ? S_FA : S_WB;
        end
        S_WB:   state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode only the registered state, so reset clears them immediately.
  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.opa_load    = 1'b0;
    bus.ac_clear    = 1'b0;
    bus.ac_alu_load = 1'b0;
    bus.done        = 1'b0;
    bus.busy        = (state_q != S_IDLE);
    case (state_q)
      S_CLR: bus.ac_clear = 1'b1;
      S_FA: begin
        bus.mem_addr = a_ptr_q;
        bus.mem_rd   = 1'b1;
      end
      S_FB: begin
        bus.mem_addr = b_ptr_q;
        bus.mem_rd   = 1'b1;
        bus.opa_load = 1'b1;
      end
      S_MAC: bus.ac_alu_load = 1'b1;
      S_WB: begin
        bus.mem_addr = c_addr_q;
        bus.mem_wr   = 1'b1;
      end
      S_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - directed and randomized bench with memory/accumulator model and dot-product reference
module tb_mac_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_sequencer_if #(.AW(8), .LW(8)) bus ();

  mac_sequencer #(.AW(8), .LW(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [15:0] mem [256];
  logic [15:0] rdata;
  logic [15:0] opa;
  logic [15:0] ac;
  int ncmp = 0;
  int nfail = 0;

  // Environment: single-port memory with one-cycle read latency, operand register, accumulator.
  always @(posedge clk) begin
    if (bus.mem_rd) rdata <= mem[bus.mem_addr];
    if (bus.opa_load) opa <= rdata;
    if (bus.ac_clear) ac <= 16'h0;
    else if (bus.ac_alu_load) ac <= ac + opa * rdata;
    if (bus.mem_wr) mem[bus.mem_addr] <= ac;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {17'h0, bus.mem_addr, bus.mem_rd, bus.mem_wr, bus.opa_load,
            bus.ac_clear, bus.ac_alu_load, bus.busy, bus.done};
  endfunction

  // mode: 0 plain, 1 start re-pulsed in MAC of element 1, 2 abort in FB of element 2, 3 reset in FA
  task automatic run_op(input string name, input int n, input int a, input int b, input int s,
                        input int c, input int mode);
    int exp_rd[$];
    int got_rd[$];
    int wr_addr[$];
    int nbusy, ndone, done_cyc, nclr, excl, cyc;
    logic fb_seen;
    logic [15:0] exp_sum;
    mem[c & 255] = 16'hBEEF;
    exp_sum = 16'h0;
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back((a + i) & 255);
      exp_rd.push_back((b + i * s) & 255);
      exp_sum = exp_sum + mem[(a + i) & 255] * mem[(b + i * s) & 255];
    end
    nbusy = 0; ndone = 0; done_cyc = 0; nclr = 0; excl = 0; fb_seen = 1'b0;
    bus.start = 1'b1;
    bus.len = 8'(n); bus.a_base = 8'(a); bus.b_base = 8'(b);
    bus.b_stride = 8'(s); bus.c_addr = 8'(c);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (bus.busy === 1'b1 && cyc < 200) begin
      nbusy++;
      if (bus.mem_rd) got_rd.push_back(int'(bus.mem_addr));
      if (bus.mem_wr) wr_addr.push_back(int'(bus.mem_addr));
      if (bus.ac_clear) nclr++;
      if (bus.done) begin ndone++; done_cyc = cyc; end
      if ((bus.ac_clear && bus.ac_alu_load) || (bus.mem_rd && bus.mem_wr)) excl++;
      if (mode == 1 && cyc == 4) begin
        bus.start = 1'b1; bus.len = 8'd7; bus.a_base = 8'h00;
        bus.b_base = 8'h01; bus.b_stride = 8'h01; bus.c_addr = 8'hAA;
      end
      if (mode == 2 && cyc == 6) begin
        fb_seen = bus.opa_load;
        bus.abort = 1'b1;
      end
      if (mode == 3 && cyc == 2) begin
        #2 rst_n = 1'b0;
        #1 check({name, " outs zero in reset"}, outs(), 32'h0);
      end
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      bus.abort = 1'b0;
    end
    check({name, " no timeout"}, 32'(cyc >= 200), 32'h0);
    if (cyc >= 200) begin
      rst_n = 1'b0;
      @(negedge clk);
    end
    if (mode == 3 || cyc >= 200) rst_n = 1'b1;
    check({name, " exclusive strobes"}, 32'(excl), 32'h0);
    if (mode <= 1) begin
      check({name, " busy cycles"}, 32'(nbusy), 32'(3 * n + 3));
      check({name, " done cycle"}, 32'(done_cyc), 32'(3 * n + 3));
      check({name, " done count"}, 32'(ndone), 32'h1);
      check({name, " clear count"}, 32'(nclr), 32'h1);
      check({name, " read count"}, 32'(got_rd.size()), 32'(exp_rd.size()));
      for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
        check({name, " read addr"}, 32'(got_rd[i]), 32'(exp_rd[i]));
      check({name, " write count"}, 32'(wr_addr.size()), 32'h1);
      if (wr_addr.size() > 0) check({name, " write addr"}, 32'(wr_addr[0]), 32'(c & 255));
      check({name, " result"}, 32'(mem[c & 255]), 32'(exp_sum));
    end else if (mode == 2) begin
      check({name, " abort in FB"}, 32'(fb_seen), 32'h1);
      check({name, " busy cycles"}, 32'(nbusy), 32'd6);
      check({name, " no done"}, 32'(ndone), 32'h0);
      check({name, " no write"}, 32'(wr_addr.size()), 32'h0);
      check({name, " mem untouched"}, 32'(mem[c & 255]), 32'hBEEF);
    end else begin
      check({name, " reads before reset"}, 32'(got_rd.size()), 32'h1);
      if (got_rd.size() > 0) check({name, " first read"}, 32'(got_rd[0]), 32'(a & 255));
      check({name, " no done"}, 32'(ndone), 32'h0);
      check({name, " no write"}, 32'(wr_addr.size()), 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.len = '0;
    bus.a_base = '0; bus.b_base = '0; bus.b_stride = '0; bus.c_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    #12;
    check("reset outputs", outs(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset", outs(), 32'h0);

    mem[8'h10] = 16'd1; mem[8'h11] = 16'd2; mem[8'h12] = 16'd3;
    mem[8'h20] = 16'd4; mem[8'h24] = 16'd5; mem[8'h28] = 16'd6;
    run_op("basic", 3, 8'h10, 8'h20, 4, 8'h40, 0);
    check("basic literal 32", 32'(mem[8'h40]), 32'd32);

    run_op("len0", 0, 8'h33, 8'h44, 1, 8'h05, 0);
    check("len0 literal 0", 32'(mem[8'h05]), 32'd0);

    run_op("wrap", 3, 8'hFE, 8'hF0, 8'h08, 8'h60, 0);

    mem[8'h10] = 16'd1; mem[8'h11] = 16'd2; mem[8'h12] = 16'd3;
    run_op("start_busy", 3, 8'h10, 8'h20, 4, 8'h41, 1);
    check("start_busy literal 32", 32'(mem[8'h41]), 32'd32);
    check("start_busy c unwritten", 32'(mem[8'hAA] === 16'hBEEF), 32'h0);

    run_op("abort", 3, 8'h10, 8'h20, 4, 8'h42, 2);
    run_op("after_abort", 1, 8'h11, 8'h24, 0, 8'h43, 0);
    check("after_abort literal 10", 32'(mem[8'h43]), 32'd10);

    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.len = 8'd2;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start+abort idle", 32'(bus.busy), 32'h0);

    run_op("reset_fa", 2, 8'h70, 8'h80, 2, 8'h44, 3);
    run_op("after_reset", 2, 8'h70, 8'h80, 2, 8'h45, 0);

    for (int k = 0; k < 8; k++) begin
      run_op("random", int'($urandom_range(0, 12)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
